// File: rtl/z80_cb_shift_mem_seq.sv
// ============================================================================
//  Module      : z80_cb_shift_mem_seq
//  Description : Read-modify-write sequencer for CB-prefix rotate/shift ops on
//                (HL)/(IX+d)/(IY+d); owns the memory port while busy.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_cb_shift_mem_seq #(
    parameter int ALLOW_SLL   = 0,
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] addr,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        err,
    output logic [7:0]  result,
    output logic [7:0]  f_out
);

    localparam logic [2:0] c_exec_load = 3'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_EXEC    = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4,
        S_ILLEGAL = 3'd5
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [2:0]  r_f_keep;      // {f_in[5], f_in[3], f_in[0]} latched at launch
    logic [7:0]  r_operand;
    logic [2:0]  r_cnt;

    logic        w_illegal;
    logic        w_carry_in;
    logic        w_carry;
    logic [7:0]  w_result;
    logic [7:0]  w_flags;
    logic        w_unused_f_in;

    assign w_illegal     = (op == 3'd6) && (ALLOW_SLL == 0);
    assign w_unused_f_in = ^{f_in[7:6], f_in[4], f_in[2:1]};
    assign w_carry_in    = r_f_keep[0];

    always_comb begin
        w_result = r_operand;
        case (r_op)
            3'd0:    w_result = {r_operand[6:0], r_operand[7]};
            3'd1:    w_result = {r_operand[0], r_operand[7:1]};
            3'd2:    w_result = {r_operand[6:0], w_carry_in};
            3'd3:    w_result = {w_carry_in, r_operand[7:1]};
            3'd4:    w_result = {r_operand[6:0], 1'b0};
            3'd5:    w_result = {r_operand[7], r_operand[7:1]};
            3'd6:    w_result = {r_operand[6:0], 1'b1};
            default: w_result = {1'b0, r_operand[7:1]};
        endcase
        // Even op codes shift left and lose bit 7; odd ones lose bit 0.
        w_carry = r_op[0] ? r_operand[0] : r_operand[7];
        w_flags = {w_result[7], (w_result == 8'h00), r_f_keep[2], 1'b0,
                   r_f_keep[1], ~^w_result, 1'b0, w_carry};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_f_keep  <= 3'd0;
            r_operand <= 8'h00;
            r_cnt     <= 3'd0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= 8'h00;
            f_out     <= 8'h00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_f_keep <= {f_in[5], f_in[3], f_in[0]};
                        busy     <= 1'b1;
                        if (w_illegal) begin
                            err     <= 1'b1;
                            r_state <= S_ILLEGAL;
                        end else begin
                            mem_addr <= addr;
                            mem_rd   <= 1'b1;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_ILLEGAL: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_READ: begin
                    if (mem_ack) begin
                        r_operand <= mem_rdata;
                        mem_rd    <= 1'b0;
                        r_cnt     <= c_exec_load;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 3'd0) begin
                        mem_wdata <= w_result;
                        mem_wr    <= 1'b1;
                        r_state   <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_wr  <= 1'b0;
                        result  <= w_result;
                        f_out   <= w_flags;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_z80_cb_shift_mem_seq.sv
// ============================================================================
//  Module      : tb_z80_cb_shift_mem_seq
//  Description : Directed self-checking bench for z80_cb_shift_mem_seq.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80_cb_shift_mem_seq;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        ack_a   = 1'b0;
    logic        ack_b   = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [15:0] addr    = 16'h0000;
    logic [7:0]  f_in    = 8'h00;
    logic [7:0]  rdata   = 8'hEE;

    logic        busy_a, rd_a, wr_a, done_a, err_a;
    logic        busy_b, rd_b, wr_b, done_b, err_b;
    logic [15:0] maddr_a, maddr_b;
    logic [7:0]  wdata_a, wdata_b, result_a, result_b, f_out_a, f_out_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    z80_cb_shift_mem_seq #(.ALLOW_SLL(0), .EXEC_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .op(op), .addr(addr), .f_in(f_in),
        .busy(busy_a), .mem_rd(rd_a), .mem_wr(wr_a), .mem_addr(maddr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata), .mem_ack(ack_a),
        .done(done_a), .err(err_a), .result(result_a), .f_out(f_out_a)
    );

    z80_cb_shift_mem_seq #(.ALLOW_SLL(1), .EXEC_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .op(op), .addr(addr), .f_in(f_in),
        .busy(busy_b), .mem_rd(rd_b), .mem_wr(wr_b), .mem_addr(maddr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata), .mem_ack(ack_b),
        .done(done_b), .err(err_b), .result(result_b), .f_out(f_out_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op on instance a (sel=0) or b (sel=1), act as memory with the
    // given wait states, and check bus behaviour, latency and results.
    task automatic run_op(input bit sel, input string tag, input logic [2:0] t_op,
                          input logic [15:0] t_addr, input logic [7:0] t_f,
                          input logic [7:0] t_mem, input int rd_wait, input int wr_wait,
                          input logic [7:0] exp_res, input logic [7:0] exp_f,
                          input int exp_lat, input bit poke);
        int   rd_cnt   = 0;
        int   wr_cnt   = 0;
        int   lat      = 0;
        bit   got      = 1'b0;
        bit   both     = 1'b0;
        bit   bad_addr = 1'b0;
        bit   bad_wd   = 1'b0;
        logic o_rd, o_wr, o_done, o_busy;
        op = t_op; addr = t_addr; f_in = t_f; rdata = 8'hEE;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0; rdata = 8'hEE;
            o_rd   = sel ? rd_b   : rd_a;
            o_wr   = sel ? wr_b   : wr_a;
            o_done = sel ? done_b : done_a;
            o_busy = sel ? busy_b : busy_a;
            if (o_rd && o_wr) both = 1'b1;
            if (o_done) begin
                got = 1'b1;
                lat = c;
                check_eq({tag, "/busy_in_done"}, o_busy, 1'b1);
                check_eq({tag, "/result"}, sel ? result_b : result_a, exp_res);
                check_eq({tag, "/f_out"},  sel ? f_out_b  : f_out_a,  exp_f);
            end else if (o_rd) begin
                if ((sel ? maddr_b : maddr_a) !== t_addr) bad_addr = 1'b1;
                if (rd_cnt == rd_wait) begin
                    rdata = t_mem;
                    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
                end
                rd_cnt++;
            end else if (o_wr) begin
                if ((sel ? maddr_b : maddr_a) !== t_addr) bad_addr = 1'b1;
                if ((sel ? wdata_b : wdata_a) !== exp_res) bad_wd = 1'b1;
                if (wr_cnt == wr_wait) begin
                    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
                end
                wr_cnt++;
            end
            if (poke && c == 2) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                op = 3'd0; addr = 16'hFFFF; f_in = 8'h00;
            end
        end
        check_eq({tag, "/done_seen"}, got, 1'b1);
        check_eq({tag, "/latency"}, lat, exp_lat);
        check_eq({tag, "/rd_cycles"}, rd_cnt, rd_wait + 1);
        check_eq({tag, "/wr_cycles"}, wr_cnt, wr_wait + 1);
        check_eq({tag, "/addr_stable"}, bad_addr, 1'b0);
        check_eq({tag, "/wdata_stable"}, bad_wd, 1'b0);
        check_eq({tag, "/rd_wr_excl"}, both, 1'b0);
        @(posedge clk); #1;
        check_eq({tag, "/done_pulse"}, sel ? done_b : done_a, 1'b0);
        check_eq({tag, "/busy_drop"},  sel ? busy_b : busy_a, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst/busy",  {busy_a, busy_b}, 2'b00);
        check_eq("rst/rdwr",  {rd_a, wr_a, rd_b, wr_b}, 4'h0);
        check_eq("rst/pulse", {done_a, err_a, done_b, err_b}, 4'h0);
        check_eq("rst/addr",  {maddr_a, maddr_b}, 32'h0);
        check_eq("rst/data",  {wdata_a, result_a, f_out_a, result_b}, 32'h0);

        //     sel tag       op    addr      f_in   mem    rw ww  result f_out  lat poke
        run_op(0, "rlc",     3'd0, 16'h1234, 8'h00, 8'h85, 0, 0, 8'h0B, 8'h01, 4,  0);
        run_op(0, "sra",     3'd5, 16'hABCD, 8'h28, 8'h81, 0, 0, 8'hC0, 8'hAD, 4,  0);
        run_op(0, "rr",      3'd3, 16'h0100, 8'h00, 8'h01, 0, 0, 8'h00, 8'h45, 4,  0);
        run_op(0, "rl_c1",   3'd2, 16'h0200, 8'h01, 8'h7F, 0, 0, 8'hFF, 8'h84, 4,  0);
        run_op(0, "sla",     3'd4, 16'h0300, 8'h00, 8'hC3, 0, 0, 8'h86, 8'h81, 4,  0);
        run_op(0, "rrc",     3'd1, 16'h0400, 8'h08, 8'h02, 0, 0, 8'h01, 8'h08, 4,  0);
        run_op(0, "srl_wait",3'd7, 16'h5A5A, 8'hFF, 8'hA6, 3, 3, 8'h53, 8'h2C, 10, 1);

        // Illegal SLL on the instance that forbids it
        op = 3'd6; addr = 16'h2222; f_in = 8'hFF; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        check_eq("ill/err",  err_a, 1'b1);
        check_eq("ill/busy", busy_a, 1'b1);
        check_eq("ill/bus",  {rd_a, wr_a}, 2'b00);
        @(posedge clk); #1;
        check_eq("ill/err_pulse", err_a, 1'b0);
        check_eq("ill/busy_drop", busy_a, 1'b0);
        check_eq("ill/bus2", {rd_a, wr_a}, 2'b00);
        check_eq("ill/held", {result_a, f_out_a}, 16'h532C);

        run_op(1, "sll",     3'd6, 16'h0800, 8'h00, 8'h80, 0, 0, 8'h01, 8'h01, 6,  0);
        run_op(1, "srl_b",   3'd7, 16'h0900, 8'h00, 8'h01, 1, 0, 8'h00, 8'h45, 7,  0);

        // Reset while a write is waiting for ack
        op = 3'd0; addr = 16'h4444; f_in = 8'h00; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; ack_a = 1'b1; rdata = 8'h85;
        @(posedge clk); #1; ack_a = 1'b0; rdata = 8'hEE;
        @(posedge clk); #1;
        check_eq("rstw/wr_before", wr_a, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_eq("rstw/wr",   wr_a, 1'b0);
        check_eq("rstw/busy", busy_a, 1'b0);
        check_eq("rstw/res",  {result_a, f_out_a}, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        run_op(0, "after_rst", 3'd2, 16'h4444, 8'h29, 8'h80, 0, 0, 8'h01, 8'h29, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
